multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the RV32I-subset core (R-type ALU, I-type ALU, `lw`, `sw`, `beq`). It sequences the shared datapath through fetch, decode, execute, memory and writeback over several cycles. The datapath is one ALU, one unified memory port and the immediate generator. The block drives every mux select and write enable and handshakes with memory. It also counts retired instructions and traps on unsupported opcodes.

## Interface
- No parameters.
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `start_i` in 1: leave IDLE and begin fetching; sampled only in IDLE.
- `instr_i` in 32: current IR contents (opcode = [6:0], funct3 = [14:12], funct7 = [31:25]).
- `zero_i` in 1: ALU zero flag, combinational from the current cycle.
- `mem_ready_i` in 1: memory completes the pending access this cycle.
- `mem_req_o` out 1: memory access request.
- `mem_we_o` out 1: write access (valid with `mem_req_o`).
- `mem_addr_sel_o` out 1: 0 = PC, 1 = ALUOut.
- `ir_write_o` out 1: latch memory read data into IR (and PC into oldPC).
- `mdr_write_o` out 1: latch memory read data into MDR.
- `pc_write_o` out 1: PC update enable.
- `pc_src_o` out 1: 0 = ALU result, 1 = Target register.
- `target_write_o` out 1: latch ALU result into Target register.
- `alu_src_a_o` out 2: 00 = PC, 01 = oldPC, 10 = rs1.
- `alu_src_b_o` out 2: 00 = rs2, 01 = constant 4, 10 = imm, 11 = imm<<1.
- `alu_op_o` out 2: 00 = ADD, 01 = SUB, 10 = decode from funct3/funct7.
- `reg_write_o` out 1: register file write enable.
- `wb_sel_o` out 1: 0 = ALUOut, 1 = MDR.
- `busy_o` out 1: high in every state except IDLE and TRAP.
- `trap_o` out 1: sticky illegal-opcode flag.
- `instret_o` out 32: retired-instruction counter.

## Operation
- ALUOut is latched by the datapath every cycle. The block issues no enable for it.
- Outputs are Moore-decoded from the state. In states that wait on memory, they also depend on `mem_ready_i`/`zero_i` as listed. Any output not listed for a state is 0.
- IDLE: if `start_i`, go to FETCH.
- FETCH:
  - `mem_req_o` = 1, `mem_addr_sel_o` = 0.
  - On `mem_ready_i`, also drive `ir_write_o` = 1, `pc_write_o` = 1, `pc_src_o` = 0, a = 00, b = 01, op = ADD (PC ← PC + 4), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - a = 01, b = 11, op = ADD, `target_write_o` = 1 (Target ← oldPC + imm<<1).
  - Next state by opcode: 0110011 or 0010011 → EXEC_ALU; 0000011 or 0100011 → EXEC_ADDR; 1100011 → EXEC_BR; any other opcode → TRAP.
- EXEC_ALU:
  - a = 10, op = 10; b = 00 for 0110011, b = 10 for 0010011.
  - Go to WB.
- EXEC_ADDR: a = 10, b = 10, op = ADD; go to MEM.
- EXEC_BR:
  - a = 10, b = 00, op = SUB, `pc_src_o` = 1, `pc_write_o` = `zero_i`.
  - Retire; go to FETCH.
- MEM:
  - `mem_req_o` = 1, `mem_addr_sel_o` = 1, `mem_we_o` = (opcode == 0100011).
  - On `mem_ready_i`: `sw` retires and goes to FETCH; `lw` drives `mdr_write_o` = 1 and goes to WB.
  - Otherwise stay in MEM.
- WB:
  - `reg_write_o` = 1, `wb_sel_o` = (opcode == 0000011).
  - Retire; go to FETCH.
- TRAP: `trap_o` = 1; all enables 0; remain in TRAP until `rst_i`.
- Retire: `instret_o` increments by 1 on the edge leaving the retiring state, wrapping from 0xFFFFFFFF to 0.
- `instr_i` is decoded only in DECODE, EXEC_*, MEM and WB. IR is written only in FETCH, so it is stable there.

## Timing
- On `rst_i` at a rising edge:
  - State becomes IDLE and `instret_o` becomes 0.
  - All 1-bit outputs are 0 and `alu_src_a_o`, `alu_src_b_o`, `alu_op_o` are 00.
  - `rst_i` has priority over every transition, including mid-memory-access and TRAP.
  - An outstanding request is dropped; a `mem_ready_i` in the reset cycle is ignored.
- With zero-wait memory (`mem_ready_i` = 1 in the first request cycle), cycles per instruction are: `beq` 3, R/I-ALU 4, `sw` 4, `lw` 5.
- Each wait cycle adds 1 in FETCH or MEM. `mem_req_o` stays high and its address select stays fixed until `mem_ready_i`.
- `mem_ready_i` is ignored when `mem_req_o` = 0.
- `start_i` is ignored outside IDLE. IDLE → FETCH takes 1 cycle.

## Test plan
- Reset: assert `rst_i` during MEM of a `lw` with `mem_ready_i` = 0 → next cycle state IDLE, `mem_req_o` = 0, `instret_o` = 0; a `mem_ready_i` pulse then causes no write enables.
- R-type: `add` (0x002081B3), zero-wait → exactly 4 cycles FETCH → DECODE → EXEC_ALU (a = 10, b = 00, op = 10) → WB (`reg_write_o` = 1, `wb_sel_o` = 0); `instret_o` 0 → 1.
- `lw` (0x0000A183) with 2 wait cycles in FETCH and 3 in MEM → 10 cycles total; `mdr_write_o` pulses exactly once, in the ready cycle; WB has `wb_sel_o` = 1.
- `sw` (0x0030A023) → MEM drives `mem_we_o` = 1 and `mem_addr_sel_o` = 1; no `reg_write_o`; returns to FETCH after 4 cycles.
- `beq` (0x00208463): `zero_i` = 1 → `pc_write_o` = 1 with `pc_src_o` = 1 in EXEC_BR; `zero_i` = 0 → `pc_write_o` = 0; both retire in 3 cycles.
- Opcode 0x7F → TRAP after DECODE; `trap_o` = 1, `busy_o` = 0 held for 20 cycles with `start_i` toggling; `instret_o` unchanged; `rst_i` clears it.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for an RV32I-subset core
// (R/I-type ALU, lw, sw, beq). It sequences a shared datapath (one ALU,
// one unified memory port, immediate generator) through fetch, decode,
// execute, memory and writeback. It also counts retired instructions and
// traps on unsupported opcodes.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             leave IDLE and begin fetching (IDLE only)
//   instr_i[31:0]       current IR contents
//   zero_i              ALU zero flag (combinational, current cycle)
//   mem_ready_i         memory completes the pending access this cycle
//   mem_req_o/mem_we_o  memory request / write qualifier
//   mem_addr_sel_o      0 = PC, 1 = ALUOut
//   ir_write_o          latch read data into IR (and PC into oldPC)
//   mdr_write_o         latch read data into MDR
//   pc_write_o          PC update enable
//   pc_src_o            0 = ALU result, 1 = Target register
//   target_write_o      latch ALU result into Target
//   alu_src_a_o[1:0]    00 = PC, 01 = oldPC, 10 = rs1
//   alu_src_b_o[1:0]    00 = rs2, 01 = 4, 10 = imm, 11 = imm<<1
//   alu_op_o[1:0]       00 = ADD, 01 = SUB, 10 = funct decode
//   reg_write_o         register file write enable
//   wb_sel_o            0 = ALUOut, 1 = MDR
//   busy_o              high outside IDLE and TRAP
//   trap_o              sticky illegal-opcode flag
//   instret_o[31:0]     retired-instruction counter (wraps)
module multicycle_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] instr_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_addr_sel_o,
  output logic        ir_write_o,
  output logic        mdr_write_o,
  output logic        pc_write_o,
  output logic        pc_src_o,
  output logic        target_write_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic        reg_write_o,
  output logic        wb_sel_o,
  output logic        busy_o,
  output logic        trap_o,
  output logic [31:0] instret_o
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC_ALU,
    EXEC_ADDR,
    EXEC_BR,
    MEM,
    WB,
    TRAP
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       retire;
  logic [6:0] opcode;

  assign opcode = instr_i[6:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      instret_o <= '0;
    end else begin
      state <= state_next;
      if (retire) begin
        instret_o <= instret_o + 32'd1;
      end
    end
  end

  always_comb begin
    state_next     = state;
    retire         = 1'b0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    ir_write_o     = 1'b0;
    mdr_write_o    = 1'b0;
    pc_write_o     = 1'b0;
    pc_src_o       = 1'b0;
    target_write_o = 1'b0;
    alu_src_a_o    = 2'b00;
    alu_src_b_o    = 2'b00;
    alu_op_o       = 2'b00;
    reg_write_o    = 1'b0;
    wb_sel_o       = 1'b0;
    busy_o         = 1'b0;
    trap_o         = 1'b0;

    // Outputs are held quiet during the reset cycle so a completing memory
    // access cannot commit a write while the FSM is being forced to IDLE.
    if (!rst_i) begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state_next = FETCH;
          end
        end

        FETCH: begin
          busy_o    = 1'b1;
          mem_req_o = 1'b1;
          if (mem_ready_i) begin
            ir_write_o  = 1'b1;
            pc_write_o  = 1'b1;
            alu_src_b_o = 2'b01;
            state_next  = DECODE;
          end
        end

        DECODE: begin
          busy_o         = 1'b1;
          alu_src_a_o    = 2'b01;
          alu_src_b_o    = 2'b11;
          target_write_o = 1'b1;
          case (opcode)
            OP_REG, OP_IMM:    state_next = EXEC_ALU;
            OP_LOAD, OP_STORE: state_next = EXEC_ADDR;
            OP_BRANCH:         state_next = EXEC_BR;
            default:           state_next = TRAP;
          endcase
        end

        EXEC_ALU: begin
          busy_o      = 1'b1;
          alu_src_a_o = 2'b10;
          alu_src_b_o = (opcode == OP_IMM) ? 2'b10 : 2'b00;
          alu_op_o    = 2'b10;
          state_next  = WB;
        end

        EXEC_ADDR: begin
          busy_o      = 1'b1;
          alu_src_a_o = 2'b10;
          alu_src_b_o = 2'b10;
          state_next  = MEM;
        end

        EXEC_BR: begin
          busy_o      = 1'b1;
          alu_src_a_o = 2'b10;
          alu_op_o    = 2'b01;
          pc_src_o    = 1'b1;
          pc_write_o  = zero_i;
          retire      = 1'b1;
          state_next  = FETCH;
        end

        MEM: begin
          busy_o         = 1'b1;
          mem_req_o      = 1'b1;
          mem_addr_sel_o = 1'b1;
          mem_we_o       = (opcode == OP_STORE);
          if (mem_ready_i) begin
            if (opcode == OP_STORE) begin
              retire     = 1'b1;
              state_next = FETCH;
            end else begin
              mdr_write_o = 1'b1;
              state_next  = WB;
            end
          end
        end

        WB: begin
          busy_o      = 1'b1;
          reg_write_o = 1'b1;
          wb_sel_o    = (opcode == OP_LOAD);
          retire      = 1'b1;
          state_next  = FETCH;
        end

        TRAP: begin
          trap_o = 1'b1;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected output vectors
// are queued together with the stimulus for that cycle, then popped and
// compared as the DUT steps through each instruction.
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] instr_i;
  logic        zero_i;
  logic        mem_ready_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic        mem_addr_sel_o;
  logic        ir_write_o;
  logic        mdr_write_o;
  logic        pc_write_o;
  logic        pc_src_o;
  logic        target_write_o;
  logic [1:0]  alu_src_a_o;
  logic [1:0]  alu_src_b_o;
  logic [1:0]  alu_op_o;
  logic        reg_write_o;
  logic        wb_sel_o;
  logic        busy_o;
  logic        trap_o;
  logic [31:0] instret_o;

  multicycle_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .instr_i        (instr_i),
    .zero_i         (zero_i),
    .mem_ready_i    (mem_ready_i),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_sel_o (mem_addr_sel_o),
    .ir_write_o     (ir_write_o),
    .mdr_write_o    (mdr_write_o),
    .pc_write_o     (pc_write_o),
    .pc_src_o       (pc_src_o),
    .target_write_o (target_write_o),
    .alu_src_a_o    (alu_src_a_o),
    .alu_src_b_o    (alu_src_b_o),
    .alu_op_o       (alu_op_o),
    .reg_write_o    (reg_write_o),
    .wb_sel_o       (wb_sel_o),
    .busy_o         (busy_o),
    .trap_o         (trap_o),
    .instret_o      (instret_o)
  );

  always #5 clk_i = ~clk_i;

  typedef logic [17:0] ovec_t;

  typedef struct packed {
    ovec_t v;
    logic  rdy;
    logic  zr;
    logic  st;
  } stim_t;

  stim_t stim_q[$];
  int    checks   = 0;
  int    failures = 0;
  ovec_t obs;

  assign obs = {mem_req_o, mem_we_o, mem_addr_sel_o, ir_write_o, mdr_write_o,
                pc_write_o, pc_src_o, target_write_o, alu_src_a_o, alu_src_b_o,
                alu_op_o, reg_write_o, wb_sel_o, busy_o, trap_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic ovec_t ov(input logic req, we, asel, irw, mdrw, pcw, pcs, tw,
                               input logic [1:0] a, b, op,
                               input logic rw, wbs, busy, trap);
    return {req, we, asel, irw, mdrw, pcw, pcs, tw, a, b, op, rw, wbs, busy, trap};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input ovec_t v, input logic rdy, input logic zr, input logic st);
    stim_q.push_back('{v: v, rdy: rdy, zr: zr, st: st});
  endtask

  task automatic push_start();
    push('0, rnd(), 1'b0, 1'b1);
  endtask

  task automatic push_fetch(input int unsigned waits);
    for (int unsigned i = 0; i < waits; i++)
      push(ov(1,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,1,0), 1'b0, 1'b0, 1'b0);
    push(ov(1,0,0,1,0,1,0,0, 2'b00,2'b01,2'b00, 0,0,1,0), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic push_decode(input logic zr);
    push(ov(0,0,0,0,0,0,0,1, 2'b01,2'b11,2'b00, 0,0,1,0), rnd(), zr, 1'b0);
  endtask

  task automatic push_exec_addr();
    push(ov(0,0,0,0,0,0,0,0, 2'b10,2'b10,2'b00, 0,0,1,0), rnd(), 1'b0, 1'b0);
  endtask

  task automatic push_mem(input int unsigned waits, input logic store);
    for (int unsigned i = 0; i < waits; i++)
      push(ov(1,store,1,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,1,0), 1'b0, 1'b0, 1'b0);
    push(ov(1,store,1,0,!store,0,0,0, 2'b00,2'b00,2'b00, 0,0,1,0), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag);
    stim_t s;
    int    n = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      @(negedge clk_i);
      mem_ready_i = s.rdy;
      zero_i      = s.zr;
      start_i     = s.st;
      #1;
      check($sformatf("%s_c%0d", tag, n), 32'(obs), 32'(s.v));
      n++;
      @(posedge clk_i);
    end
    #1;
  endtask

  // Queue the full expected cycle sequence of one instruction, then run it.
  task automatic run_instr(input string tag, input logic [31:0] instr,
                           input int unsigned fw, input int unsigned mw, input logic zr);
    logic [6:0] opc;
    opc     = instr[6:0];
    instr_i = instr;
    push_fetch(fw);
    push_decode(zr);
    case (opc)
      7'b0110011: begin
        push(ov(0,0,0,0,0,0,0,0, 2'b10,2'b00,2'b10, 0,0,1,0), rnd(), zr, 1'b0);
        push(ov(0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,0,1,0), rnd(), zr, 1'b0);
      end
      7'b0010011: begin
        push(ov(0,0,0,0,0,0,0,0, 2'b10,2'b10,2'b10, 0,0,1,0), rnd(), zr, 1'b0);
        push(ov(0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,0,1,0), rnd(), zr, 1'b0);
      end
      7'b0000011: begin
        push_exec_addr();
        push_mem(mw, 1'b0);
        push(ov(0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,1,1,0), rnd(), 1'b0, 1'b0);
      end
      7'b0100011: begin
        push_exec_addr();
        push_mem(mw, 1'b1);
      end
      7'b1100011: begin
        push(ov(0,0,0,0,0,zr,1,0, 2'b10,2'b00,2'b01, 0,0,1,0), rnd(), zr, 1'b0);
      end
      default: ;
    endcase
    drain(tag);
  endtask

  initial begin
    rst_i       = 1'b1;
    start_i     = 1'b0;
    instr_i     = '0;
    zero_i      = 1'b0;
    mem_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("reset_out", 32'(obs), 32'd0);
    check("reset_instret", instret_o, 32'd0);

    push_start();
    run_instr("add", 32'h002081B3, 0, 0, 1'b0);
    check("add_instret", instret_o, 32'd1);
    run_instr("addi", 32'h00108093, 0, 0, 1'b0);
    check("addi_instret", instret_o, 32'd2);
    run_instr("lw", 32'h0000A183, 2, 3, 1'b0);
    check("lw_instret", instret_o, 32'd3);
    run_instr("sw", 32'h0030A023, 0, 0, 1'b0);
    check("sw_instret", instret_o, 32'd4);
    run_instr("beq_t", 32'h00208463, 0, 0, 1'b1);
    check("beq_t_instret", instret_o, 32'd5);
    run_instr("beq_nt", 32'h00208463, 1, 0, 1'b0);
    check("beq_nt_instret", instret_o, 32'd6);

    // lw interrupted by reset while waiting in MEM
    instr_i = 32'h0000A183;
    push_fetch(0);
    push_decode(1'b0);
    push_exec_addr();
    push(ov(1,0,1,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,1,0), 1'b0, 1'b0, 1'b0);
    drain("lw_pre_rst");
    @(negedge clk_i);
    rst_i       = 1'b1;
    mem_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i       = 1'b0;
    mem_ready_i = 1'b0;
    #1;
    check("mem_rst_out", 32'(obs), 32'd0);
    check("mem_rst_instret", instret_o, 32'd0);
    repeat (3) push('0, 1'b1, 1'b0, 1'b0);
    drain("idle_ready");

    push_start();
    run_instr("add2", 32'h002081B3, 0, 0, 1'b0);
    check("add2_instret", instret_o, 32'd1);

    // Illegal opcode: TRAP is sticky regardless of start/ready
    run_instr("illegal", 32'h0000007F, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++)
      push(ov(0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0,1), rnd(), 1'b0, 1'(i % 2));
    drain("trap");
    check("trap_instret", instret_o, 32'd1);
    @(negedge clk_i);
    rst_i   = 1'b1;
    start_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("trap_rst_out", 32'(obs), 32'd0);
    check("trap_rst_instret", instret_o, 32'd0);

    push_start();
    run_instr("sw2", 32'h0030A023, 1, 2, 1'b0);
    check("sw2_instret", instret_o, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
